// File: rtl/dense_layer_1_readout_pkg.sv
// Shared constants and types for the dense layer 1 readout and later readouts.
package dense_layer_1_readout_pkg;

    // Layer geometry for the first dense layer.
    localparam int IN_SIZE_1     = 16;
    localparam int OUT_SIZE_1    = 10;

    // Accumulator width, activation width and requantisation shift.
    localparam int DENSE_ACC_W   = 24;
    localparam int ACT_W         = 16;
    localparam int READOUT_SHIFT = 8;

    // Sequencer phases: wait, accumulate + ReLU, neuron scan, result hand-off.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } readout_state_t;

    // Counter/index width that stays at least one bit for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dense_layer_1_readout_requant_sat.sv
// Combinational requantiser: arithmetic right shift of a signed accumulator,
// then clamp into the unsigned activation range [0, 2^OUT_W-1].
module requant_sat #(
    parameter int ACC_W = 24,
    parameter int OUT_W = 16,
    parameter int SHIFT = 8
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [OUT_W-1:0] q_o
);

    // Work in a width that can hold both the accumulator and the clamp limit.
    localparam int W = ACC_W + OUT_W + 1;
    localparam logic signed [W-1:0] MAX_V = {{(W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    logic signed [W-1:0] wide;
    logic signed [W-1:0] shifted;

    // Sign-extend, shift, then saturate negative to zero and large to all ones.
    always_comb begin
        wide    = {{(W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
        shifted = wide >>> SHIFT;
        if (shifted[W-1]) begin
            q_o = '0;
        end else if (shifted > MAX_V) begin
            q_o = {OUT_W{1'b1}};
        end else begin
            q_o = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/dense_layer_1_readout.sv
// Sequencer and reader for dense layer 1: releases the layer from clear,
// waits out accumulate + ReLU, scans and requantises each neuron, tracks the
// argmax, and offers the result downstream with valid/ready.
module dense_layer_1_readout
    import dense_layer_1_readout_pkg::*;
#(
    parameter int IN_SIZE  = IN_SIZE_1,
    parameter int OUT_SIZE = OUT_SIZE_1,
    parameter int ACC_W    = DENSE_ACC_W,
    parameter int OUT_W    = ACT_W,
    parameter int SHIFT    = READOUT_SHIFT,
    localparam int IDX_W   = idx_width(OUT_SIZE),
    localparam int CNT_W   = idx_width(IN_SIZE + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    output logic                      busy_o,
    output logic                      layer_clear_o,
    input  logic [ACC_W*OUT_SIZE-1:0] acc_vector_i,
    output logic [OUT_W*OUT_SIZE-1:0] out_vector_o,
    output logic [IDX_W-1:0]          max_idx_o,
    output logic [OUT_W-1:0]          max_val_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i
);

    readout_state_t            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      clear_q, clear_d;
    logic                      valid_q, valid_d;
    logic [OUT_W*OUT_SIZE-1:0] outVector_q, outVector_d;
    logic [IDX_W-1:0]          maxIdx_q, maxIdx_d;
    logic [OUT_W-1:0]          maxVal_q, maxVal_d;

    logic [ACC_W-1:0]          accSel;
    logic [OUT_W-1:0]          quant;

    // Select the accumulator of the neuron currently being scanned.
    always_comb begin
        accSel = '0;
        for (int i = 0; i < OUT_SIZE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                accSel = acc_vector_i[i*ACC_W +: ACC_W];
            end
        end
    end

    requant_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .acc_i (accSel),
        .q_o   (quant)
    );

    // State register; reset holds the layer in clear and wipes all results.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            clear_q     <= 1'b1;
            valid_q     <= 1'b0;
            outVector_q <= '0;
            maxIdx_q    <= '0;
            maxVal_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            clear_q     <= clear_d;
            valid_q     <= valid_d;
            outVector_q <= outVector_d;
            maxIdx_q    <= maxIdx_d;
            maxVal_q    <= maxVal_d;
        end
    end

    // Next-state logic: sequencing, per-neuron write-back and running argmax.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        clear_d     = clear_q;
        valid_d     = valid_q;
        outVector_d = outVector_q;
        maxIdx_d    = maxIdx_q;
        maxVal_d    = maxVal_q;
        case (state_q)
            IDLE: begin
                clear_d = 1'b1;
                if (start_i) begin
                    state_d = ACC;
                    clear_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            ACC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(IN_SIZE)) begin
                    state_d  = SCAN;
                    idx_d    = '0;
                    maxIdx_d = '0;
                    maxVal_d = '0;
                end
            end
            SCAN: begin
                for (int i = 0; i < OUT_SIZE; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        outVector_d[i*OUT_W +: OUT_W] = quant;
                    end
                end
                // Strict compare so ties keep the lowest index.
                if (quant > maxVal_q) begin
                    maxVal_d = quant;
                    maxIdx_d = idx_q;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(OUT_SIZE - 1)) begin
                    state_d = DONE;
                    clear_d = 1'b1;
                    valid_d = 1'b1;
                end
            end
            DONE: begin
                if (valid_q && out_ready_i) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                clear_d = 1'b1;
                valid_d = 1'b0;
            end
        endcase
    end

    assign busy_o        = (state_q == ACC) || (state_q == SCAN);
    assign layer_clear_o = clear_q;
    assign out_valid_o   = valid_q;
    assign out_vector_o  = outVector_q;
    assign max_idx_o     = maxIdx_q;
    assign max_val_o     = maxVal_q;

endmodule
